// File: rtl/sr_ff_bank.sv
// Clocked bank of WIDTH set/reset flip-flops with a configurable S=R=1 policy, sticky conflict flags and change pulses.
// Optional saturating conflict counter enabled by defining SR_FF_BANK_CONFLICT_CNT_EN.
module sr_ff_bank #(
    parameter int               WIDTH   = 8,
    parameter int               MODE    = 0,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_conflict,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] chg,
    output logic [WIDTH-1:0] conflict
`ifdef SR_FF_BANK_CONFLICT_CNT_EN
    ,
    output logic [CNT_W-1:0] conflict_cnt
`endif
);

    typedef enum logic [1:0] {
        POL_HOLD   = 2'd0,
        POL_SET    = 2'd1,
        POL_RESET  = 2'd2,
        POL_TOGGLE = 2'd3
    } policy_t;

    // Out-of-range MODE values fall back to hold.
    localparam policy_t POLICY = ((MODE >= 0) && (MODE <= 3)) ? policy_t'(MODE) : POL_HOLD;

    function automatic logic resolve_bit(input logic set_b, input logic clr_b, input logic cur_b);
        logic nxt;
        case ({set_b, clr_b})
            2'b00:   nxt = cur_b;
            2'b01:   nxt = 1'b0;
            2'b10:   nxt = 1'b1;
            2'b11: begin
                case (POLICY)
                    POL_HOLD:   nxt = cur_b;
                    POL_SET:    nxt = 1'b1;
                    POL_RESET:  nxt = 1'b0;
                    POL_TOGGLE: nxt = ~cur_b;
                    default:    nxt = cur_b;
                endcase
            end
            default: nxt = cur_b;
        endcase
        return nxt;
    endfunction

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] qn_r;
    logic [WIDTH-1:0] chg_r;
    logic [WIDTH-1:0] conflict_r;
    logic [WIDTH-1:0] q_next_s;
    logic [WIDTH-1:0] conflict_new_s;
    logic             any_conflict_s;

    // Next-state resolution; a disabled cycle reproduces q so chg falls out as zero.
    always_comb begin
        q_next_s       = q_r;
        conflict_new_s = {WIDTH{1'b0}};
        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                q_next_s[i] = resolve_bit(s[i], r[i], q_r[i]);
            end
            conflict_new_s = s & r;
        end else begin
            q_next_s       = q_r;
            conflict_new_s = {WIDTH{1'b0}};
        end
        any_conflict_s = |conflict_new_s;
    end

    // State, complement, change pulses and sticky conflict flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r        <= RST_VAL;
            qn_r       <= ~RST_VAL;
            chg_r      <= {WIDTH{1'b0}};
            conflict_r <= {WIDTH{1'b0}};
        end else begin
            q_r   <= q_next_s;
            qn_r  <= ~q_next_s;
            chg_r <= q_next_s ^ q_r;
            // A conflict arriving with the clear survives it.
            if (clr_conflict) begin
                conflict_r <= conflict_new_s;
            end else begin
                conflict_r <= conflict_r | conflict_new_s;
            end
        end
    end

    assign q        = q_r;
    assign qn       = qn_r;
    assign chg      = chg_r;
    assign conflict = conflict_r;

`ifdef SR_FF_BANK_CONFLICT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic [CNT_W-1:0] cnt_r;

    // Saturating count of enabled cycles carrying any conflict; clear plus conflict loads one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr_conflict) begin
            cnt_r <= any_conflict_s ? CNT_ONE : {CNT_W{1'b0}};
        end else if (any_conflict_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign conflict_cnt = cnt_r;
`endif

endmodule
